ex_wb_stage: RTL and testbench

EX/WB pipeline stage. It is the consumer of the EX stage's rf_waddr/rf_wdata/rf_we outputs and ex_valid handshake.
- Registers one EX result per transaction and holds loads until the LSU returns data.
- Byte-aligns and sign/zero-extends load data.
- Drives the register-file write port and the forwarding bus back to ID.
- Pulses instruction retirement.

---
 rtl/ex_wb_pkg.sv | 30 +++
 rtl/ex_wb_stage_load_formatter.sv | 33 +++
 rtl/ex_wb_stage.sv | 126 ++++++++++++
 tb/tb_ex_wb_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_wb_pkg.sv
// Shared types for the EX/WB stage: FSM states, load sizes and the captured EX result.
package ex_wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_e;

  // 2'b11 is reserved; it may still be captured and is reported as a fault.
  typedef enum logic [1:0] {
    LSU_W = 2'b00,
    LSU_H = 2'b01,
    LSU_B = 2'b10
  } lsu_type_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
    logic                 we;
    logic                 is_load;
    lsu_type_e            lsu_type;
    logic                 sign;
    logic [1:0]           offset;
  } wb_ctrl_t;

endpackage

// File: rtl/ex_wb_stage_load_formatter.sv
// Combinational load aligner: picks the addressed byte/half from the raw word and
// extends it; flags misaligned or reserved-size accesses.
module load_formatter
  import ex_wb_pkg::*;
(
  input  logic [WB_DATA_W-1:0] rdata_i,
  input  lsu_type_e            type_i,
  input  logic                 sign_i,
  input  logic [1:0]           offset_i,
  output logic [WB_DATA_W-1:0] data_o,
  output logic                 misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata_i[{offset_i, 3'b000} +: 8];
    half_sel   = rdata_i[{offset_i[1], 4'b0000} +: 16];
    data_o     = rdata_i;
    misalign_o = 1'b0;
    case (type_i)
      LSU_W: misalign_o = (offset_i != 2'b00);
      LSU_H: begin
        data_o     = {{16{sign_i & half_sel[15]}}, half_sel};
        misalign_o = offset_i[0];
      end
      LSU_B: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB stage: non-loads write one cycle after accept, loads write in the LSU response cycle;
// wb_ready_o drops only while a load waits. Perf counters built with EX_WB_PERF_CNT_EN.
module ex_wb_stage
  import ex_wb_pkg::*;
#(
  parameter int unsigned RegAddrW = 5,
  parameter int unsigned DataW    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ex_valid_i,
  output logic                wb_ready_o,
  input  logic [RegAddrW-1:0] rf_waddr_ex_i,
  input  logic [DataW-1:0]    rf_wdata_ex_i,
  input  logic                rf_we_ex_i,
  input  logic                is_load_ex_i,
  input  logic [1:0]          lsu_type_ex_i,
  input  logic                lsu_sign_ext_ex_i,
  input  logic [1:0]          lsu_offset_ex_i,
  input  logic                lsu_resp_valid_i,
  input  logic [DataW-1:0]    lsu_rdata_i,
  input  logic                lsu_resp_err_i,
  output logic                rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o,
  output logic [DataW-1:0]    rf_wdata_o,
  output logic                fwd_valid_o,
  output logic                instr_done_o,
  output logic                load_err_o,
  output logic [31:0]         retire_cnt_o,
  output logic [31:0]         load_stall_cnt_o
);

  wb_state_e state_q, state_d;
  wb_ctrl_t  ctrl_q, ctrl_d;

  logic            load_pending;
  logic            load_resp;
  logic            accept;
  logic            retire;
  logic            fault;
  logic            write_ok;
  logic [DataW-1:0] fmt_data;
  logic            fmt_misalign;

  load_formatter u_fmt (
    .rdata_i    (lsu_rdata_i),
    .type_i     (ctrl_q.lsu_type),
    .sign_i     (ctrl_q.sign),
    .offset_i   (ctrl_q.offset),
    .data_o     (fmt_data),
    .misalign_o (fmt_misalign)
  );

  assign load_pending = (state_q == WAIT_LOAD) & ctrl_q.is_load;
  assign load_resp    = load_pending & lsu_resp_valid_i;
  assign wb_ready_o   = (state_q != WAIT_LOAD) | lsu_resp_valid_i;
  assign accept       = ex_valid_i & wb_ready_o;
  assign retire       = (state_q == FULL) | load_resp;
  assign fault        = lsu_resp_err_i | fmt_misalign;

  // Retire and accept may coincide, so the slot refills without a bubble.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    if (accept) begin
      ctrl_d.waddr    = rf_waddr_ex_i;
      ctrl_d.wdata    = rf_wdata_ex_i;
      ctrl_d.we       = rf_we_ex_i;
      ctrl_d.is_load  = is_load_ex_i;
      ctrl_d.lsu_type = lsu_type_e'(lsu_type_ex_i);
      ctrl_d.sign     = lsu_sign_ext_ex_i;
      ctrl_d.offset   = lsu_offset_ex_i;
      state_d         = is_load_ex_i ? WAIT_LOAD : FULL;
    end else if (retire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // x0 is never written, but the instruction still retires.
  assign write_ok     = ctrl_q.we & (ctrl_q.waddr != '0);
  assign rf_we_o      = write_ok & ((state_q == FULL) | (load_resp & ~fault));
  assign rf_waddr_o   = ctrl_q.waddr;
  assign rf_wdata_o   = load_pending ? fmt_data : ctrl_q.wdata;
  assign fwd_valid_o  = rf_we_o;
  assign instr_done_o = retire;
  assign load_err_o   = load_resp & fault;

`ifdef EX_WB_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (retire) retire_cnt_d = retire_cnt_q + 32'd1;
    if (load_pending & ~lsu_resp_valid_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt_o     = retire_cnt_q;
  assign load_stall_cnt_o = stall_cnt_q;
`else
  assign retire_cnt_o     = '0;
  assign load_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: drives on the falling edge, checks 1ns later.
module tb_ex_wb_stage;

  logic        clk_i;
  logic        rst_ni;
  logic        ex_valid_i;
  logic        wb_ready_o;
  logic [4:0]  rf_waddr_ex_i;
  logic [31:0] rf_wdata_ex_i;
  logic        rf_we_ex_i;
  logic        is_load_ex_i;
  logic [1:0]  lsu_type_ex_i;
  logic        lsu_sign_ext_ex_i;
  logic [1:0]  lsu_offset_ex_i;
  logic        lsu_resp_valid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_resp_err_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic        instr_done_o;
  logic        load_err_o;
  logic [31:0] retire_cnt_o;
  logic [31:0] load_stall_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ret   = 0;
  int exp_stall = 0;

  ex_wb_stage dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ex_valid_i       (ex_valid_i),
    .wb_ready_o       (wb_ready_o),
    .rf_waddr_ex_i    (rf_waddr_ex_i),
    .rf_wdata_ex_i    (rf_wdata_ex_i),
    .rf_we_ex_i       (rf_we_ex_i),
    .is_load_ex_i     (is_load_ex_i),
    .lsu_type_ex_i    (lsu_type_ex_i),
    .lsu_sign_ext_ex_i(lsu_sign_ext_ex_i),
    .lsu_offset_ex_i  (lsu_offset_ex_i),
    .lsu_resp_valid_i (lsu_resp_valid_i),
    .lsu_rdata_i      (lsu_rdata_i),
    .lsu_resp_err_i   (lsu_resp_err_i),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .fwd_valid_o      (fwd_valid_o),
    .instr_done_o     (instr_done_o),
    .load_err_o       (load_err_o),
    .retire_cnt_o     (retire_cnt_o),
    .load_stall_cnt_o (load_stall_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One cycle of stimulus; outputs are checked 1ns after the falling edge.
  task automatic cyc(input logic ev, input logic [4:0] wa, input logic [31:0] wd,
                     input logic we, input logic ld, input logic [1:0] ty,
                     input logic sg, input logic [1:0] off,
                     input logic rv, input logic [31:0] rd, input logic err);
    @(negedge clk_i);
    ex_valid_i        = ev;
    rf_waddr_ex_i     = wa;
    rf_wdata_ex_i     = wd;
    rf_we_ex_i        = we;
    is_load_ex_i      = ld;
    lsu_type_ex_i     = ty;
    lsu_sign_ext_ex_i = sg;
    lsu_offset_ex_i   = off;
    lsu_resp_valid_i  = rv;
    lsu_rdata_i       = rd;
    lsu_resp_err_i    = err;
    #1;
  endtask

  task automatic idle(input logic rv, input logic [31:0] rd, input logic err);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, rv, rd, err);
  endtask

  task automatic expect_out(input string tag, input logic rdy, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd,
                            input logic done, input logic lerr);
    chk({tag, ".rdy"}, {31'b0, wb_ready_o}, {31'b0, rdy});
    chk({tag, ".we"}, {31'b0, rf_we_o}, {31'b0, we});
    chk({tag, ".fwd"}, {31'b0, fwd_valid_o}, {31'b0, we});
    if (we) begin
      chk({tag, ".waddr"}, {27'b0, rf_waddr_o}, {27'b0, wa});
      chk({tag, ".wdata"}, rf_wdata_o, wd);
    end
    chk({tag, ".done"}, {31'b0, instr_done_o}, {31'b0, done});
    chk({tag, ".lerr"}, {31'b0, load_err_o}, {31'b0, lerr});
    if (done) exp_ret++;
  endtask

  task automatic check_cnt(input string tag);
`ifdef EX_WB_PERF_CNT_EN
    chk({tag, ".retire_cnt"}, retire_cnt_o, exp_ret);
    chk({tag, ".stall_cnt"}, load_stall_cnt_o, exp_stall);
`else
    chk({tag, ".retire_cnt"}, retire_cnt_o, 32'd0);
    chk({tag, ".stall_cnt"}, load_stall_cnt_o, 32'd0);
`endif
  endtask

  initial begin
    rst_ni = 1'b0;
    ex_valid_i = 1'b0; rf_waddr_ex_i = '0; rf_wdata_ex_i = '0; rf_we_ex_i = 1'b0;
    is_load_ex_i = 1'b0; lsu_type_ex_i = '0; lsu_sign_ext_ex_i = 1'b0; lsu_offset_ex_i = '0;
    lsu_resp_valid_i = 1'b0; lsu_rdata_i = '0; lsu_resp_err_i = 1'b0;

    // Reset state
    #12;
    chk("rst.we", {31'b0, rf_we_o}, 32'd0);
    chk("rst.waddr", {27'b0, rf_waddr_o}, 32'd0);
    chk("rst.wdata", rf_wdata_o, 32'd0);
    chk("rst.done", {31'b0, instr_done_o}, 32'd0);
    chk("rst.lerr", {31'b0, load_err_o}, 32'd0);
    check_cnt("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: non-load writes one cycle after accept
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    expect_out("t1.acc", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t1.wr", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t1.after", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // 2: signed byte load at offset 2, response three cycles late
    cyc(1'b1, 5'd7, 32'h0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    expect_out("t2.acc", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 32'h0, 1'b0);
      expect_out($sformatf("t2.stall%0d", i), 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      exp_stall++;
    end
    idle(1'b1, 32'h1280_3456, 1'b0);
    check_cnt("t2.resp");
    expect_out("t2.bs", 1'b1, 1'b1, 5'd7, 32'hFFFFFF80, 1'b1, 1'b0);

    cyc(1'b1, 5'd8, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h1280_3456, 1'b0);
    expect_out("t2.bu", 1'b1, 1'b1, 5'd8, 32'h00000080, 1'b1, 1'b0);

    cyc(1'b1, 5'd9, 32'h0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h0000_9ABC, 1'b0);
    expect_out("t2.hs", 1'b1, 1'b1, 5'd9, 32'hFFFF9ABC, 1'b1, 1'b0);

    cyc(1'b1, 5'd10, 32'h0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h1280_3456, 1'b0);
    expect_out("t2.hhi", 1'b1, 1'b1, 5'd10, 32'h00001280, 1'b1, 1'b0);

    // 3: misaligned half and bus-error word both fault without writing
    cyc(1'b1, 5'd11, 32'h0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'hCAFE_F00D, 1'b0);
    expect_out("t3.hmis", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 5'd12, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'hCAFE_F00D, 1'b1);
    expect_out("t3.werr", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t3.after", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    // 4: back-to-back non-loads, then a load answered while a new op is presented
    cyc(1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    expect_out("t4.c0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b1, 5'(i), 32'(i * 17), 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
      expect_out($sformatf("t4.c%0d", i - 1), 1'b1, 1'b1, 5'(i - 1), 32'((i - 1) * 17), 1'b1, 1'b0);
    end
    cyc(1'b1, 5'd5, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    expect_out("t4.c4", 1'b1, 1'b1, 5'd4, 32'd68, 1'b1, 1'b0);
    cyc(1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 32'h5555_5555, 1'b0);
    expect_out("t4.c5", 1'b1, 1'b1, 5'd5, 32'h5555_5555, 1'b1, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t4.c6", 1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0);

    // 5: write to x0 is suppressed but still retires
    cyc(1'b1, 5'd0, 32'h1234_5678, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t5.x0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    check_cnt("t5");

    // 6: reset while a load waits drops it; a late response is ignored
    cyc(1'b1, 5'd13, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h0, 1'b0);
    expect_out("t6.wait", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    exp_ret = 0;
    exp_stall = 0;
    check_cnt("t6.rst");
    rst_ni = 1'b1;
    idle(1'b1, 32'hFFFF_FFFF, 1'b0);
    expect_out("t6.late", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("t6.waddr", {27'b0, rf_waddr_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
